step_pulse_gen: RTL

Upstream motion-command stage that turns queued move segments into the step/dir pulse pair consumed by the dual H-bridge stage. Each move segment gives a step count, a direction, an initial step period and a signed per-step period delta (linear ramp). The stage enforces direction-setup time and minimum step pulse width, and reports completion to the command queue.

---
 rtl/step_pulse_gen.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: turns queued move segments into a step/dir pulse pair.
// Linear period ramp with saturation, dir setup, halt without runt pulses.
module step_pulse_gen #(
  parameter int CNT_W        = 32,
  parameter int TMR_W        = 24,
  parameter int PULSE_W      = 8,
  parameter int DIR_SETUP    = 16,
  parameter int MIN_INTERVAL = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             move_valid,
  output logic             move_ready,
  input  logic [CNT_W-1:0] move_steps,
  input  logic             move_dir,
  input  logic [TMR_W-1:0] move_interval,
  input  logic [TMR_W-1:0] move_delta,
  input  logic             halt,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic [CNT_W-1:0] steps_left,
  output logic             move_done,
  output logic             aborted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_HIGH   = 3'd2;
  localparam logic [2:0] S_LOW    = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [TMR_W-1:0] MIN_IV = TMR_W'(MIN_INTERVAL);
  localparam logic [TMR_W-1:0] PW     = TMR_W'(PULSE_W);
  localparam logic [TMR_W-1:0] DS     = TMR_W'(DIR_SETUP);
  localparam logic signed [TMR_W+1:0] MIN_S =
    (TMR_W+2)'(MIN_INTERVAL);
  localparam logic signed [TMR_W+1:0] MAX_S =
    {2'b00, {TMR_W{1'b1}}};

  logic [2:0]       state_q, state_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             halt_q, halt_d;
  logic [TMR_W-1:0] ival_q, ival_d;
  logic [TMR_W-1:0] delta_q, delta_d;
  logic [TMR_W-1:0] per_q, per_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic             accept;
  logic             expired;
  logic             halt_any;
  logic [TMR_W-1:0] per_eff;
  logic [TMR_W-1:0] ival_nxt;
  logic signed [TMR_W+1:0] sum_s;

  assign move_ready = (state_q == S_IDLE) && !halt;
  assign accept     = move_valid && move_ready;
  assign expired    = tmr_q >= per_q;
  assign halt_any   = halt || halt_q;
  assign per_eff    = (ival_q < MIN_IV) ? MIN_IV : ival_q;

  // Ramp step in two extra bits so both wrap directions are visible.
  always_comb begin
    sum_s = $signed({2'b00, ival_q})
          + $signed({{2{delta_q[TMR_W-1]}}, delta_q});
    if (sum_s < MIN_S) begin
      ival_nxt = MIN_IV;
    end else if (sum_s > MAX_S) begin
      ival_nxt = '1;
    end else begin
      ival_nxt = sum_s[TMR_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    left_d  = left_q;
    done_d  = 1'b0;
    abort_d = abort_q;
    halt_d  = halt_q;
    ival_d  = ival_q;
    delta_d = delta_q;
    per_d   = per_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          busy_d  = 1'b1;
          left_d  = move_steps;
          ival_d  = move_interval;
          delta_d = move_delta;
          abort_d = 1'b0;
          halt_d  = 1'b0;
          tmr_d   = '0;
          // per=0 makes LOW fire on the very next edge
          per_d   = '0;
          if (move_steps != '0 && move_dir != dir_q) begin
            dir_d   = move_dir;
            state_d = S_SETUP;
          end else begin
            state_d = S_LOW;
          end
        end
      end
      S_SETUP: begin
        tmr_d = tmr_q + 1'b1;
        if (halt) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          abort_d = 1'b1;
        end else if (tmr_q == DS) begin
          step_d  = 1'b1;
          state_d = S_HIGH;
          tmr_d   = TMR_W'(1);
          left_d  = left_q - 1'b1;
          per_d   = per_eff;
          ival_d  = ival_nxt;
        end
      end
      S_HIGH: begin
        tmr_d = tmr_q + 1'b1;
        if (halt) halt_d = 1'b1;
        if (tmr_q == PW) begin
          step_d = 1'b0;
          if (halt_any) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            abort_d = 1'b1;
            halt_d  = 1'b0;
          end else begin
            state_d = S_LOW;
          end
        end
      end
      S_LOW: begin
        tmr_d = tmr_q + 1'b1;
        if (expired && left_q == '0) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          abort_d = 1'b0;
        end else if (halt) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          abort_d = 1'b1;
        end else if (expired) begin
          step_d  = 1'b1;
          state_d = S_HIGH;
          tmr_d   = TMR_W'(1);
          left_d  = left_q - 1'b1;
          per_d   = per_eff;
          ival_d  = ival_nxt;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      left_q  <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      halt_q  <= 1'b0;
      ival_q  <= '0;
      delta_q <= '0;
      per_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      left_q  <= left_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      halt_q  <= halt_d;
      ival_q  <= ival_d;
      delta_q <= delta_d;
      per_q   <= per_d;
      tmr_q   <= tmr_d;
    end
  end

  assign step       = step_q;
  assign dir        = dir_q;
  assign busy       = busy_q;
  assign steps_left = left_q;
  assign move_done  = done_q;
  assign aborted    = abort_q;

endmodule
